// File: rtl/bp_be_dual_issue_ctrl_pkg.sv
// Shared types for the BE dual-issue scheduler: the FSM state enum, the
// pre-decoded issue packet layout and the queue-depth constant.
package bp_be_dual_issue_ctrl_pkg;

    // Depth of the FE queue. Caps how many issued-but-uncommitted
    // instructions the scheduler allows.
    localparam int fe_queue_fifo_els_gp = 8;

    typedef enum logic [1:0] {
        e_run    = 2'd0,
        e_drain  = 2'd1,
        e_serial = 2'd2,
        e_roll   = 2'd3
    } bp_be_issue_ctrl_state_e;

    // Pre-decoded issue packet: pipe-class flags plus source-operand usage.
    typedef struct packed {
        logic       csr_v;
        logic       fence_v;
        logic       mem_v;
        logic       long_v;
        logic       irs1_v;
        logic       irs2_v;
        logic       frs1_v;
        logic       frs2_v;
        logic       frs3_v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } bp_be_issue_pkt_s;

    localparam int issue_pkt_width_gp = $bits(bp_be_issue_pkt_s);

    // CSR and fence instructions must run alone with an empty pipeline.
    function automatic logic is_serializing(input bp_be_issue_pkt_s pkt);
        return pkt.csr_v | pkt.fence_v;
    endfunction

endpackage

// File: rtl/bp_be_dual_issue_ctrl_pair_check.sv
// Decides whether the head+1 packet may issue alongside the head packet:
// no serializing instruction in the pair, no shared memory or long-latency
// pipe, and no read-after-write dependence on the head's destination.
module bp_be_dual_issue_ctrl_pair_check
    import bp_be_dual_issue_ctrl_pkg::*;
(
    input  bp_be_issue_pkt_s iss0_pkt_i,
    input  bp_be_issue_pkt_s iss1_pkt_i,
    input  logic [1:0]       iss0_rd_v_i,
    input  logic [4:0]       iss0_rd_i,
    output logic             pair_ok_o
);

    logic raw_int;
    logic raw_fp;
    logic any_serial;
    logic struct_hazard;

    // x0 is hardwired to zero, so an int write to x0 never creates a dependence.
    assign raw_int = iss0_rd_v_i[0] & (iss0_rd_i != 5'd0)
                   & ((iss1_pkt_i.irs1_v & (iss1_pkt_i.rs1 == iss0_rd_i))
                    | (iss1_pkt_i.irs2_v & (iss1_pkt_i.rs2 == iss0_rd_i)));

    // f0 is an ordinary register, so no zero-address exemption here.
    assign raw_fp = iss0_rd_v_i[1]
                  & ((iss1_pkt_i.frs1_v & (iss1_pkt_i.rs1 == iss0_rd_i))
                   | (iss1_pkt_i.frs2_v & (iss1_pkt_i.rs2 == iss0_rd_i))
                   | (iss1_pkt_i.frs3_v & (iss1_pkt_i.rs3 == iss0_rd_i)));

    assign any_serial = is_serializing(iss0_pkt_i) | is_serializing(iss1_pkt_i);

    // Only one memory pipe and one long-latency pipe exist.
    assign struct_hazard = (iss0_pkt_i.mem_v & iss1_pkt_i.mem_v)
                         | (iss0_pkt_i.long_v & iss1_pkt_i.long_v);

    assign pair_ok_o = ~(raw_int | raw_fp | any_serial | struct_hazard);

    // The head's own source operands never matter for pairing.
    logic unused_src;
    assign unused_src = ^{iss0_pkt_i.irs1_v, iss0_pkt_i.irs2_v, iss0_pkt_i.frs1_v,
                          iss0_pkt_i.frs2_v, iss0_pkt_i.frs3_v, iss0_pkt_i.rs1,
                          iss0_pkt_i.rs2, iss0_pkt_i.rs3};

endmodule

// File: rtl/bp_be_dual_issue_ctrl.sv
// BE issue scheduler for the dual-issue core. Looks at the two oldest issue
// queue entries and issues 0, 1 or 2 of them per cycle, tracks the number of
// issued-but-uncommitted instructions, serializes CSR/fence, and drives the
// queue's yumi, checkpoint dequeue, rollback and clear controls.
//
// Handshake: iss*_v_i is the queue's valid, dispatch_rdy_i is the slot ready;
// an entry is consumed exactly when counted in yumi_cnt_o, which only counts
// entries that are valid and whose slot is ready in that same cycle, oldest
// first (slot1 never without slot0).
module bp_be_dual_issue_ctrl
    import bp_be_dual_issue_ctrl_pkg::*;
#(
    parameter  int fe_queue_fifo_els_p = fe_queue_fifo_els_gp,
    localparam int inflight_max_lp     = fe_queue_fifo_els_p,
    localparam int cnt_width_lp        = $clog2(inflight_max_lp + 1)
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  bp_be_issue_pkt_s        iss0_pkt_i,
    input  logic                    iss0_v_i,
    input  logic [1:0]              iss0_rd_v_i,
    input  logic [4:0]              iss0_rd_i,
    input  bp_be_issue_pkt_s        iss1_pkt_i,
    input  logic                    iss1_v_i,
    input  logic [1:0]              dispatch_rdy_i,
    input  logic [1:0]              commit_cnt_i,
    input  logic                    flush_v_i,
    input  logic                    roll_req_i,
    output logic [1:0]              yumi_cnt_o,
    output logic [1:0]              deq_cnt_o,
    output logic                    roll_v_o,
    output logic                    clr_v_o,
    output logic [cnt_width_lp-1:0] inflight_o,
    output logic                    serial_o,
    output bp_be_issue_ctrl_state_e state_o
);

    localparam logic [cnt_width_lp:0] max_lp = (cnt_width_lp+1)'(inflight_max_lp);
    localparam logic [cnt_width_lp:0] two_lp = (cnt_width_lp+1)'(2);

    bp_be_issue_ctrl_state_e state_r;
    logic [cnt_width_lp-1:0] inflight_r;
    logic                    roll_v_r;
    logic                    clr_v_r;
    logic                    serial_r;

    logic                    pair_ok;
    logic                    slot0_ok;
    logic                    slot1_ok;
    logic                    head_serial;
    logic                    issue_en;
    logic [cnt_width_lp:0]   inflight_ext;
    logic [cnt_width_lp:0]   inflight_sum;

    bp_be_dual_issue_ctrl_pair_check pair_check (
        .iss0_pkt_i  (iss0_pkt_i),
        .iss1_pkt_i  (iss1_pkt_i),
        .iss0_rd_v_i (iss0_rd_v_i),
        .iss0_rd_i   (iss0_rd_i),
        .pair_ok_o   (pair_ok)
    );

    // Slot eligibility and the per-cycle issue count.
    always_comb begin
        inflight_ext = {1'b0, inflight_r};
        head_serial  = iss0_v_i & is_serializing(iss0_pkt_i);
        slot0_ok     = iss0_v_i & dispatch_rdy_i[0] & (inflight_ext < max_lp);
        slot1_ok     = slot0_ok & iss1_v_i & dispatch_rdy_i[1]
                     & ((inflight_ext + two_lp) <= max_lp) & pair_ok;
        issue_en     = ~reset_i & ~flush_v_i & ~roll_req_i & (state_r == e_run);
        yumi_cnt_o   = 2'd0;
        if (issue_en) begin
            if (head_serial) begin
                // A serializing head only goes when nothing else is in flight.
                yumi_cnt_o = ((inflight_r == '0) && slot0_ok) ? 2'd1 : 2'd0;
            end else if (slot1_ok) begin
                yumi_cnt_o = 2'd2;
            end else if (slot0_ok) begin
                yumi_cnt_o = 2'd1;
            end
        end
        inflight_sum = inflight_ext + (cnt_width_lp+1)'(yumi_cnt_o)
                     - (cnt_width_lp+1)'(commit_cnt_i);
        deq_cnt_o    = (reset_i | flush_v_i | roll_req_i) ? 2'd0 : commit_cnt_i;
    end

    // Scheduler FSM, in-flight counter and registered strobes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_run;
            inflight_r <= '0;
            roll_v_r   <= 1'b0;
            clr_v_r    <= 1'b0;
            serial_r   <= 1'b0;
        end else if (flush_v_i) begin
            state_r    <= e_run;
            inflight_r <= '0;
            roll_v_r   <= 1'b0;
            clr_v_r    <= 1'b1;
            serial_r   <= 1'b0;
        end else if (roll_req_i) begin
            state_r    <= e_roll;
            inflight_r <= '0;
            roll_v_r   <= 1'b1;
            clr_v_r    <= 1'b0;
            serial_r   <= 1'b0;
        end else begin
            inflight_r <= inflight_sum[cnt_width_lp-1:0];
            roll_v_r   <= 1'b0;
            clr_v_r    <= 1'b0;
            case (state_r)
                e_run: begin
                    if (head_serial) begin
                        if (yumi_cnt_o != 2'd0) begin
                            state_r  <= e_serial;
                            serial_r <= 1'b1;
                        end else if (inflight_r != '0) begin
                            state_r <= e_drain;
                        end
                    end
                end
                e_drain: begin
                    if (inflight_sum == '0) state_r <= e_run;
                end
                e_serial: begin
                    if (inflight_sum == '0) begin
                        state_r  <= e_run;
                        serial_r <= 1'b0;
                    end
                end
                e_roll: begin
                    // Queue valid is low for the replay cycle; resume next.
                    state_r <= e_run;
                end
                default: begin
                    state_r <= e_run;
                end
            endcase
        end
    end

    // Interface sanity: commits never exceed what is in flight, never 3,
    // and a flush always masks a same-cycle rollback.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (commit_cnt_i != 2'd3);
            assert ({1'b0, commit_cnt_i} <= {1'b0, inflight_ext});
            assert (!(roll_v_r && clr_v_r));
            assert (inflight_ext <= max_lp);
        end
    end

    assign roll_v_o   = roll_v_r;
    assign clr_v_o    = clr_v_r;
    assign inflight_o = inflight_r;
    assign serial_o   = serial_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_bp_be_dual_issue_ctrl.sv
// Bench for bp_be_dual_issue_ctrl: directed scenarios with hand-computed
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the scheduler rules.
module tb_bp_be_dual_issue_ctrl;
    import bp_be_dual_issue_ctrl_pkg::*;

    localparam int max_c = fe_queue_fifo_els_gp;
    localparam int cw_c  = $clog2(max_c + 1);

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset_i;
    bp_be_issue_pkt_s        iss0_pkt, iss1_pkt;
    logic                    iss0_v, iss1_v;
    logic [1:0]              iss0_rd_v;
    logic [4:0]              iss0_rd;
    logic [1:0]              rdy, commit;
    logic                    flush, roll;
    logic [1:0]              yumi, deq;
    logic                    roll_v, clr_v, serial;
    logic [cw_c-1:0]         inflight;
    bp_be_issue_ctrl_state_e state;

    bp_be_dual_issue_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .iss0_pkt_i     (iss0_pkt),
        .iss0_v_i       (iss0_v),
        .iss0_rd_v_i    (iss0_rd_v),
        .iss0_rd_i      (iss0_rd),
        .iss1_pkt_i     (iss1_pkt),
        .iss1_v_i       (iss1_v),
        .dispatch_rdy_i (rdy),
        .commit_cnt_i   (commit),
        .flush_v_i      (flush),
        .roll_req_i     (roll),
        .yumi_cnt_o     (yumi),
        .deq_cnt_o      (deq),
        .roll_v_o       (roll_v),
        .clr_v_o        (clr_v),
        .inflight_o     (inflight),
        .serial_o       (serial),
        .state_o        (state)
    );

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];
    int last_yumi;

    int m_inflight;
    bit m_drain, m_serial, m_roll_gap, m_clr_q, m_roll_q;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pair_ok(input bp_be_issue_pkt_s a, input bp_be_issue_pkt_s b,
                                     input logic [1:0] rd_v, input logic [4:0] rd);
        bit raw;
        raw = 0;
        if (rd_v[0] && rd != 0 && ((b.irs1_v && b.rs1 == rd) || (b.irs2_v && b.rs2 == rd))) raw = 1;
        if (rd_v[1] && ((b.frs1_v && b.rs1 == rd) || (b.frs2_v && b.rs2 == rd) ||
                        (b.frs3_v && b.rs3 == rd))) raw = 1;
        if (a.csr_v || a.fence_v || b.csr_v || b.fence_v) return 0;
        if (a.mem_v && b.mem_v) return 0;
        if (a.long_v && b.long_v) return 0;
        return !raw;
    endfunction

    // One clock: check comb outputs against the model, advance the model,
    // then check registered outputs after the edge. Returns at a negedge.
    task automatic cycle();
        int ey, ed, old_inf;
        bit was_run, head_ser;
        #1;
        head_ser = iss0_v && (iss0_pkt.csr_v || iss0_pkt.fence_v);
        ey = 0;
        if (reset_i || flush || roll || m_drain || m_serial || m_roll_gap) ey = 0;
        else if (head_ser) ey = (m_inflight == 0 && rdy[0]) ? 1 : 0;
        else if (iss0_v && rdy[0] && m_inflight < max_c) begin
            ey = 1;
            if (iss1_v && rdy[1] && m_inflight + 2 <= max_c &&
                m_pair_ok(iss0_pkt, iss1_pkt, iss0_rd_v, iss0_rd)) ey = 2;
        end
        ed = (reset_i || flush || roll) ? 0 : int'(commit);
        exp_q.push_back(2'(ey));
        check("yumi_cnt", int'(yumi), int'(exp_q.pop_front()));
        check("deq_cnt", int'(deq), ed);
        last_yumi = int'(yumi);

        old_inf = m_inflight;
        was_run = !(m_drain || m_serial || m_roll_gap);
        if (reset_i) begin
            m_inflight = 0; m_drain = 0; m_serial = 0; m_roll_gap = 0; m_clr_q = 0; m_roll_q = 0;
        end else if (flush) begin
            m_inflight = 0; m_drain = 0; m_serial = 0; m_roll_gap = 0; m_clr_q = 1; m_roll_q = 0;
        end else if (roll) begin
            m_inflight = 0; m_drain = 0; m_serial = 0; m_roll_gap = 1; m_clr_q = 0; m_roll_q = 1;
        end else begin
            m_inflight = m_inflight + ey - int'(commit);
            m_clr_q = 0; m_roll_q = 0; m_roll_gap = 0;
            if (m_drain && m_inflight == 0) m_drain = 0;
            if (m_serial && m_inflight == 0) m_serial = 0;
            if (was_run && head_ser) begin
                if (ey == 1) m_serial = 1;
                else if (old_inf != 0) m_drain = 1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("clr_v", int'(clr_v), int'(m_clr_q));
        check("roll_v", int'(roll_v), int'(m_roll_q));
        check("inflight", int'(inflight), m_inflight);
        check("serial", int'(serial), int'(m_serial));
    endtask

    // ---------------- driver helpers ----------------
    function automatic bp_be_issue_pkt_s mk_alu(input int s1, input int s2);
        bp_be_issue_pkt_s p;
        p = '0;
        p.irs1_v = 1; p.irs2_v = 1; p.rs1 = 5'(s1); p.rs2 = 5'(s2);
        return p;
    endfunction

    function automatic bp_be_issue_pkt_s mk_load(input int s1);
        bp_be_issue_pkt_s p;
        p = '0;
        p.mem_v = 1; p.irs1_v = 1; p.rs1 = 5'(s1);
        return p;
    endfunction

    function automatic bp_be_issue_pkt_s mk_csr();
        bp_be_issue_pkt_s p;
        p = '0;
        p.csr_v = 1;
        return p;
    endfunction

    function automatic bp_be_issue_pkt_s rand_pkt();
        bp_be_issue_pkt_s p;
        p.csr_v   = ($urandom_range(0, 15) == 0);
        p.fence_v = ($urandom_range(0, 23) == 0);
        p.mem_v   = ($urandom_range(0, 2) == 0);
        p.long_v  = ($urandom_range(0, 3) == 0);
        p.irs1_v  = 1'($urandom_range(0, 1));
        p.irs2_v  = 1'($urandom_range(0, 1));
        p.frs1_v  = ($urandom_range(0, 3) == 0);
        p.frs2_v  = ($urandom_range(0, 3) == 0);
        p.frs3_v  = ($urandom_range(0, 5) == 0);
        p.rs1     = 5'($urandom_range(0, 7));
        p.rs2     = 5'($urandom_range(0, 7));
        p.rs3     = 5'($urandom_range(0, 7));
        return p;
    endfunction

    task automatic set_iss(input bp_be_issue_pkt_s p0, input logic v0, input logic [1:0] rdv,
                           input int rd, input bp_be_issue_pkt_s p1, input logic v1);
        iss0_pkt = p0; iss0_v = v0; iss0_rd_v = rdv; iss0_rd = 5'(rd);
        iss1_pkt = p1; iss1_v = v1;
    endtask

    task automatic idle();
        set_iss('0, 0, 2'b00, 0, '0, 0);
        commit = 0; flush = 0; roll = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_i = 1; rdy = 2'b11;
        idle();
        m_inflight = 0; m_drain = 0; m_serial = 0; m_roll_gap = 0; m_clr_q = 0; m_roll_q = 0;
        cycle();
        cycle();
        check("rst_inflight", int'(inflight), 0);
        check("rst_serial", int'(serial), 0);
        check("rst_strobes", int'({clr_v, roll_v}), 0);
        reset_i = 0;

        // Independent ALU pair issues together.
        set_iss(mk_alu(2, 3), 1, 2'b01, 1, mk_alu(5, 6), 1);
        cycle();
        check("alu_pair_yumi", last_yumi, 2);
        check("alu_pair_inflight", int'(inflight), 2);

        // RAW on x1: only head issues, then the dependent goes alone.
        set_iss(mk_alu(2, 3), 1, 2'b01, 1, mk_alu(1, 2), 1);
        cycle();
        check("raw_yumi", last_yumi, 1);
        set_iss(mk_alu(1, 2), 1, 2'b01, 7, '0, 0);
        cycle();
        check("raw_second_yumi", last_yumi, 1);
        check("raw_inflight", int'(inflight), 4);

        // Two loads split; load + ALU pair.
        set_iss(mk_load(2), 1, 2'b01, 3, mk_load(4), 1);
        cycle();
        check("two_loads_yumi", last_yumi, 1);
        set_iss(mk_load(2), 1, 2'b01, 3, mk_alu(5, 6), 1);
        cycle();
        check("load_alu_yumi", last_yumi, 2);
        check("load_alu_inflight", int'(inflight), 7);

        // Capacity limit.
        set_iss(mk_alu(2, 3), 1, 2'b01, 1, mk_alu(5, 6), 1);
        cycle();
        check("max_m1_yumi", last_yumi, 1);
        cycle();
        check("full_yumi", last_yumi, 0);
        commit = 1;
        cycle();
        check("full_commit_yumi", last_yumi, 0);
        commit = 0;
        cycle();
        check("after_commit_yumi", last_yumi, 1);
        check("after_commit_inflight", int'(inflight), max_c);

        // Drain down to 3.
        set_iss('0, 0, 2'b00, 0, '0, 0);
        commit = 2; cycle(); cycle();
        commit = 1; cycle();
        check("drain_to3", int'(inflight), 3);

        // CSR head waits for drain, then runs alone.
        set_iss(mk_csr(), 1, 2'b01, 9, mk_alu(5, 6), 1);
        commit = 0; cycle();
        check("csr_wait_yumi", last_yumi, 0);
        commit = 2; cycle();
        check("csr_drain_yumi", last_yumi, 0);
        commit = 1; cycle();
        check("csr_drain0_yumi", last_yumi, 0);
        commit = 0; cycle();
        check("csr_issue_yumi", last_yumi, 1);
        check("csr_serial", int'(serial), 1);
        set_iss(mk_alu(2, 3), 1, 2'b01, 1, mk_alu(5, 6), 1);
        cycle();
        check("serial_block_yumi", last_yumi, 0);
        commit = 1; cycle();
        check("serial_clear", int'(serial), 0);
        commit = 0; cycle();
        check("post_serial_yumi", last_yumi, 2);
        cycle();
        check("pre_roll_inflight", int'(inflight), 4);

        // Rollback.
        roll = 1; cycle();
        check("roll_req_yumi", last_yumi, 0);
        check("roll_pulse", int'(roll_v), 1);
        check("roll_inflight", int'(inflight), 0);
        roll = 0; cycle();
        check("roll_gap_yumi", last_yumi, 0);
        check("roll_pulse_end", int'(roll_v), 0);
        cycle();
        check("post_roll_yumi", last_yumi, 2);

        // Flush and roll together: flush wins.
        flush = 1; roll = 1; cycle();
        check("flush_clr", int'(clr_v), 1);
        check("flush_no_roll", int'(roll_v), 0);
        flush = 0; roll = 0; cycle();
        check("flush_clr_end", int'(clr_v), 0);
        check("post_flush_yumi", last_yumi, 2);

        // Reset while serializing.
        commit = 2; idle(); commit = 2; cycle();
        commit = 0;
        set_iss(mk_csr(), 1, 2'b00, 0, '0, 0);
        cycle();
        check("rst_ser_enter", int'(serial), 1);
        reset_i = 1; cycle();
        check("rst_ser_serial", int'(serial), 0);
        check("rst_ser_inflight", int'(inflight), 0);
        check("rst_ser_strobes", int'({clr_v, roll_v}), 0);
        reset_i = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_iss(rand_pkt(), 1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 7)), rand_pkt(), 1'($urandom_range(0, 3) != 0));
            rdy    = 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 3);
            commit = 2'($urandom_range(0, (m_inflight < 2) ? m_inflight : 2));
            flush  = ($urandom_range(0, 59) == 0);
            roll   = ($urandom_range(0, 44) == 0);
            reset_i = ($urandom_range(0, 299) == 0);
            if (reset_i) commit = 0;
            cycle();
        end
        reset_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
